// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: ALU opcodes, branch/MDU funct3 codes
// and the MDU state encoding.
package ex_stage_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  localparam logic [5:0] MDU_LAST_ITER = 6'd31;

endpackage

// File: rtl/ex_stage_mdu.sv
// Iterative RV32M unit: radix-2 shift-add multiply, restoring divide,
// sign fix-up applied combinationally while in DONE.
//
// state | meaning
// IDLE  | waiting for start; latches operand magnitudes and result sign
// BUSY  | one multiply/divide iteration per cycle, cnt_q 0..31
// DONE  | result_o valid for exactly one cycle, then back to IDLE
module ex_mdu
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        skip_q, skip_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;

  logic        a_sgn, b_sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh;
  logic [63:0] prod;
  logic [31:0] quot, remv;

  always_comb begin
    a_sgn = a_i[31] & ((op_i == MDU_MULH) | (op_i == MDU_MULHSU) |
                       (op_i == MDU_DIV) | (op_i == MDU_REM));
    b_sgn = b_i[31] & ((op_i == MDU_MULH) | (op_i == MDU_DIV) | (op_i == MDU_REM));
    a_mag = a_sgn ? -a_i : a_i;
    b_mag = b_sgn ? -b_i : b_i;
  end

  // Divide: opa_q[31:0] shifts dividend out / quotient in, acc_q holds remainder.
  // Multiply: opa_q is the shifting multiplicand, opb_q the multiplier, acc_q the product.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    skip_d  = skip_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_sh  = {acc_q[31:0], opa_q[31]};
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          cnt_d   = '0;
          acc_d   = '0;
          skip_d  = 1'b0;
          opa_d   = {32'd0, a_mag};
          opb_d   = b_mag;
          state_d = MDU_BUSY;
          if (op_i[2]) begin
            neg_d = op_i[1] ? a_sgn : (a_sgn ^ b_sgn);
            if (b_i == 32'd0) begin
              skip_d  = 1'b1;
              neg_d   = 1'b0;
              acc_d   = {32'd0, op_i[1] ? a_i : 32'hFFFF_FFFF};
              state_d = MDU_DONE;
            end else if (!op_i[0] && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
              skip_d  = 1'b1;
              neg_d   = 1'b0;
              acc_d   = {32'd0, op_i[1] ? 32'd0 : 32'h8000_0000};
              state_d = MDU_DONE;
            end
          end else begin
            neg_d = a_sgn ^ b_sgn;
          end
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MDU_LAST_ITER) state_d = MDU_DONE;
        if (op_q[2]) begin
          if (rem_sh >= {1'b0, opb_q}) begin
            acc_d = {31'd0, rem_sh - {1'b0, opb_q}};
            opa_d = {32'd0, opa_q[30:0], 1'b1};
          end else begin
            acc_d = {31'd0, rem_sh};
            opa_d = {32'd0, opa_q[30:0], 1'b0};
          end
        end else begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush_i && state_q != MDU_IDLE) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      skip_q  <= 1'b0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      skip_q  <= skip_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    quot     = neg_q ? -opa_q[31:0] : opa_q[31:0];
    remv     = neg_q ? -acc_q[31:0] : acc_q[31:0];
    result_o = '0;
    if (state_q == MDU_DONE) begin
      if (skip_q) begin
        result_o = acc_q[31:0];
      end else begin
        case (op_q)
          MDU_MUL:                result_o = prod[31:0];
          MDU_MULH, MDU_MULHSU,
          MDU_MULHU:              result_o = prod[63:32];
          MDU_DIV, MDU_DIVU:      result_o = quot;
          default:                result_o = remv;
        endcase
      end
    end
  end

  assign busy_o = start_i & ~flush_i & (state_q != MDU_DONE);
  assign done_o = (state_q == MDU_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, branch compare and redirect target.
// The RV32M unit is only built when EX_MDU_EN is defined.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_EX,
  input  logic [31:0] imm_EX,
  input  logic [31:0] rs1_rdata_EX,
  input  logic [31:0] rs2_rdata_EX,
  input  logic        ALU_src_EX,
  input  logic [3:0]  ALU_ctrl_EX,
  input  logic [2:0]  funct3_EX,
  input  logic        branch_EX,
  input  logic        jal_EX,
  input  logic        jalr_EX,
  input  logic        mdu_en_EX,
  input  logic        flush_EX,
  output logic [31:0] ALU_result_EX,
  output logic [31:0] PC_target_EX,
  output logic        PC_sel_EX,
  output logic        stall_EX
);

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        taken;
  logic [31:0] mdu_out;

  assign op_b  = ALU_src_EX ? imm_EX : rs2_rdata_EX;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (ALU_ctrl_EX)
      ALU_ADD:   alu_res = rs1_rdata_EX + op_b;
      ALU_SUB:   alu_res = rs1_rdata_EX - op_b;
      ALU_SLL:   alu_res = rs1_rdata_EX << shamt;
      ALU_SLT:   alu_res = {31'd0, $signed(rs1_rdata_EX) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, rs1_rdata_EX < op_b};
      ALU_XOR:   alu_res = rs1_rdata_EX ^ op_b;
      ALU_SRL:   alu_res = rs1_rdata_EX >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(rs1_rdata_EX) >>> shamt);
      ALU_OR:    alu_res = rs1_rdata_EX | op_b;
      ALU_AND:   alu_res = rs1_rdata_EX & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3_EX)
      BR_EQ:   taken = rs1_rdata_EX == rs2_rdata_EX;
      BR_NE:   taken = rs1_rdata_EX != rs2_rdata_EX;
      BR_LT:   taken = $signed(rs1_rdata_EX) < $signed(rs2_rdata_EX);
      BR_GE:   taken = $signed(rs1_rdata_EX) >= $signed(rs2_rdata_EX);
      BR_LTU:  taken = rs1_rdata_EX < rs2_rdata_EX;
      BR_GEU:  taken = rs1_rdata_EX >= rs2_rdata_EX;
      default: taken = 1'b0;
    endcase
  end

`ifdef EX_MDU_EN
  logic mdu_busy, mdu_done;
  logic [31:0] mdu_result;

  ex_mdu u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdu_en_EX),
    .op_i     (funct3_EX),
    .a_i      (rs1_rdata_EX),
    .b_i      (rs2_rdata_EX),
    .flush_i  (flush_EX),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );

  // Reset gating keeps the pipeline free while rst_n is held low.
  assign stall_EX = mdu_busy & rst_n;
  assign mdu_out  = (mdu_done & ~flush_EX) ? mdu_result : 32'd0;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
  assign stall_EX = 1'b0;
  assign mdu_out  = 32'd0;
`endif

  assign PC_target_EX = jalr_EX ? ((rs1_rdata_EX + imm_EX) & ~32'd1) : (PC_EX + imm_EX);
  assign PC_sel_EX    = (jal_EX | jalr_EX | (branch_EX & taken)) & ~flush_EX & ~stall_EX;

  always_comb begin
    if (jal_EX || jalr_EX)  ALU_result_EX = PC_EX + 32'd4;
    else if (mdu_en_EX)     ALU_result_EX = mdu_out;
    else                    ALU_result_EX = alu_res;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural model;
// MDU checks are built only when EX_MDU_EN is defined.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_EX, imm_EX, rs1_rdata_EX, rs2_rdata_EX;
  logic        ALU_src_EX;
  logic [3:0]  ALU_ctrl_EX;
  logic [2:0]  funct3_EX;
  logic        branch_EX, jal_EX, jalr_EX, mdu_en_EX, flush_EX;
  logic [31:0] ALU_result_EX, PC_target_EX;
  logic        PC_sel_EX, stall_EX;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_EX         (PC_EX),
    .imm_EX        (imm_EX),
    .rs1_rdata_EX  (rs1_rdata_EX),
    .rs2_rdata_EX  (rs2_rdata_EX),
    .ALU_src_EX    (ALU_src_EX),
    .ALU_ctrl_EX   (ALU_ctrl_EX),
    .funct3_EX     (funct3_EX),
    .branch_EX     (branch_EX),
    .jal_EX        (jal_EX),
    .jalr_EX       (jalr_EX),
    .mdu_en_EX     (mdu_en_EX),
    .flush_EX      (flush_EX),
    .ALU_result_EX (ALU_result_EX),
    .PC_target_EX  (PC_target_EX),
    .PC_sel_EX     (PC_sel_EX),
    .stall_EX      (stall_EX)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * (32'd1 << sh);
      4'd3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = int'(a);
    longint sb = int'(b);
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    logic [63:0] p;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] exp_cycles(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 32'd1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd1;
    return 32'd33;
  endfunction

  task automatic idle_inputs();
    branch_EX = 0; jal_EX = 0; jalr_EX = 0; flush_EX = 0; mdu_en_EX = 0;
    ALU_ctrl_EX = 4'd15; ALU_src_EX = 0; funct3_EX = 0;
    PC_EX = 0; imm_EX = 0; rs1_rdata_EX = 0; rs2_rdata_EX = 0;
  endtask

  task automatic drive_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    branch_EX = 0; jal_EX = 0; jalr_EX = 0; flush_EX = 0;
    ALU_ctrl_EX = 4'd15; ALU_src_EX = 0;
    funct3_EX = op; rs1_rdata_EX = a; rs2_rdata_EX = b; mdu_en_EX = 1;
  endtask

  // Leaves the DUT in DONE with mdu_en_EX still asserted.
  task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    drive_mdu(op, a, b);
    @(negedge clk);
    while (stall_EX === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall_cycles"}, 32'(n), exp_cycles(op, a, b));
    check({tag, " result"}, ALU_result_EX, mdu_ref(op, a, b));
    check({tag, " done_stall"}, {31'd0, stall_EX}, 32'd0);
  endtask

  task automatic release_mdu();
    @(posedge clk); #1;
    mdu_en_EX = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_res, e_tgt;
    logic        e_sel;
    int          cls;

    idle_inputs();
    rst_n = 0;
    PC_EX = 32'h40; jal_EX = 1; mdu_en_EX = 1;
    #2;
    check("rst stall", {31'd0, stall_EX}, 32'd0);
    check("rst pc_sel", {31'd0, PC_sel_EX}, 32'd1);
    check("rst link", ALU_result_EX, 32'h44);
    jal_EX = 0;
    #1;
    check("rst pc_sel_off", {31'd0, PC_sel_EX}, 32'd0);
    mdu_en_EX = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    @(negedge clk);
    idle_inputs();
    ALU_ctrl_EX = 4'd1; rs1_rdata_EX = 5; rs2_rdata_EX = 7;
    #1;
    check("sub 5-7", ALU_result_EX, 32'hFFFF_FFFE);
    check("sub stall", {31'd0, stall_EX}, 32'd0);

    @(negedge clk);
    idle_inputs();
    branch_EX = 1; funct3_EX = 3'b110; rs1_rdata_EX = 1; rs2_rdata_EX = 32'hFFFF_FFFF;
    PC_EX = 32'h100; imm_EX = 32'h20;
    #1;
    check("bltu pc_sel", {31'd0, PC_sel_EX}, 32'd1);
    check("bltu target", PC_target_EX, 32'h120);

    @(negedge clk);
    idle_inputs();
    jalr_EX = 1; rs1_rdata_EX = 32'h203; imm_EX = 0; PC_EX = 32'h40;
    #1;
    check("jalr target", PC_target_EX, 32'h202);
    check("jalr link", ALU_result_EX, 32'h44);
    check("jalr pc_sel", {31'd0, PC_sel_EX}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      idle_inputs();
      rs1_rdata_EX = $urandom;
      rs2_rdata_EX = ($urandom_range(0, 3) == 0) ? rs1_rdata_EX : $urandom;
      imm_EX = $urandom;
      PC_EX = $urandom & 32'hFFFF_FFFC;
      ALU_src_EX = 1'($urandom_range(0, 1));
      ALU_ctrl_EX = 4'($urandom_range(0, 15));
      funct3_EX = 3'($urandom_range(0, 7));
      cls = $urandom_range(0, 3);
      branch_EX = (cls == 1); jal_EX = (cls == 2); jalr_EX = (cls == 3);
      flush_EX = ($urandom_range(0, 7) == 0);
`ifndef EX_MDU_EN
      mdu_en_EX = (cls == 0) && ($urandom_range(0, 3) == 0);
`endif
      #2;
      if (jal_EX || jalr_EX) e_res = PC_EX + 4;
      else if (mdu_en_EX)    e_res = 0;
      else e_res = alu_ref(ALU_ctrl_EX, rs1_rdata_EX, ALU_src_EX ? imm_EX : rs2_rdata_EX);
      e_tgt = jalr_EX ? ((rs1_rdata_EX + imm_EX) & 32'hFFFF_FFFE) : (PC_EX + imm_EX);
      e_sel = (jal_EX || jalr_EX || (branch_EX && br_ref(funct3_EX, rs1_rdata_EX, rs2_rdata_EX))) && !flush_EX;
      check($sformatf("rnd%0d result op%0d", i, ALU_ctrl_EX), ALU_result_EX, e_res);
      check($sformatf("rnd%0d target", i), PC_target_EX, e_tgt);
      check($sformatf("rnd%0d pc_sel f3=%0d", i, funct3_EX), {31'd0, PC_sel_EX}, {31'd0, e_sel});
      check($sformatf("rnd%0d stall", i), {31'd0, stall_EX}, 32'd0);
    end
    @(negedge clk);
    idle_inputs();

`ifdef EX_MDU_EN
    run_mdu("mul -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mul const", ALU_result_EX, 32'hFFFF_FFEB);
    release_mdu();
    @(negedge clk);
    check("mul one_cycle", ALU_result_EX, 32'd0);
    check("mul idle stall", {31'd0, stall_EX}, 32'd0);

    run_mdu("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    release_mdu();
    run_mdu("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    release_mdu();
    run_mdu("divu by0", 3'd5, 32'd1234, 32'd0);
    release_mdu();
    run_mdu("rem by0", 3'd6, 32'hFFFF_FF00, 32'd0);
    release_mdu();

    run_mdu("b2b div", 3'd4, 32'd100, 32'd7);
    run_mdu("b2b remu", 3'd7, 32'hDEAD_BEEF, 32'd1000);
    release_mdu();

    drive_mdu(3'd4, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush_EX = 1;
    #1;
    check("flush stall", {31'd0, stall_EX}, 32'd0);
    check("flush result", ALU_result_EX, 32'd0);
    @(posedge clk); #1;
    flush_EX = 0; mdu_en_EX = 0;
    @(negedge clk);
    check("post_flush result", ALU_result_EX, 32'd0);
    run_mdu("div after flush", 3'd4, 32'd100, 32'd7);
    release_mdu();

    drive_mdu(3'd4, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst stall", {31'd0, stall_EX}, 32'd0);
    mdu_en_EX = 0;
    @(negedge clk);
    rst_n = 1;
    run_mdu("div after rst", 3'd4, 32'd100, 32'd7);
    release_mdu();

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 300)) - 32'd150;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_mdu($sformatf("mdu%0d op%0d", i, op), op, a, b);
      if ($urandom_range(0, 1) == 0) release_mdu();
    end
    release_mdu();
`else
    for (int i = 0; i < 6; i++) begin
      drive_mdu(3'(i), $urandom, $urandom);
      @(negedge clk);
      check($sformatf("nomdu%0d stall", i), {31'd0, stall_EX}, 32'd0);
      check($sformatf("nomdu%0d result", i), ALU_result_EX, 32'd0);
    end
    release_mdu();
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 Operand inputs SHALL be:
- PC_EX input 32, instruction PC.
- imm_EX input 32, immediate.
- rs1_rdata_EX input 32, rs1 value.
- rs2_rdata_EX input 32, rs2 value.
REQ-003 Control inputs SHALL be:
- ALU_src_EX input 1: 1 selects imm_EX as operand B, 0 selects rs2.
- ALU_ctrl_EX input 4: ALU opcode.
- funct3_EX input 3: branch condition, or MDU operation.
- branch_EX, jal_EX, jalr_EX input 1 each: control-transfer class.
- mdu_en_EX input 1: instruction is an RV32M operation.
- flush_EX input 1: kill the instruction in EX.
REQ-004 Outputs SHALL be:
- ALU_result_EX output 32: result; PC+4 for jal/jalr.
- PC_target_EX output 32: redirect address.
- PC_sel_EX output 1: redirect fetch this cycle.
- stall_EX output 1: hold IF/ID/EX.

Function
REQ-005 ALU codes SHALL be ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10; codes 11-15 SHALL yield 0.
REQ-006 Shift amount SHALL be operand B[4:0]; all arithmetic SHALL be modulo 2^32.
REQ-007 Branch compare SHALL use rs1 vs rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 SHALL be not-taken.
REQ-008 PC_target_EX SHALL be PC_EX+imm_EX for branch/jal and (rs1+imm_EX)&~1 for jalr.
REQ-009 PC_sel_EX SHALL be (jal | jalr | branch&taken) & ~flush_EX & ~stall_EX.
REQ-010 The ALU/branch path SHALL be combinational: zero latency.
REQ-011 The MDU SHALL use an FSM with states IDLE, BUSY, DONE:
- IDLE->BUSY on mdu_en_EX & ~flush_EX.
- BUSY->DONE after 32 iterations (6-bit counter 0..31).
- DONE->IDLE unconditionally.
REQ-012 MDU funct3 SHALL select MUL000 MULH001 MULHSU010 MULHU011 DIV100 DIVU101 REM110 REMU111.
REQ-013 Multiply SHALL be radix-2 shift-add over 64-bit magnitude; division SHALL be restoring; sign correction SHALL be applied in DONE.
REQ-014 stall_EX SHALL be 1 when mdu_en_EX=1 and state is IDLE or BUSY; stall_EX SHALL be 0 in DONE.
REQ-015 ALU_result_EX SHALL carry the MDU result in DONE: 33 cycles after acceptance, stall high for 33 cycles.
REQ-016 Divide by zero SHALL skip iteration (IDLE->DONE):
- Quotient SHALL be 0xFFFFFFFF.
- Remainder SHALL be the dividend.
REQ-017 Signed 0x80000000/-1 SHALL skip iteration:
- Quotient SHALL be 0x80000000.
- Remainder SHALL be 0.
REQ-018 flush_EX in BUSY or DONE SHALL force IDLE next cycle with stall_EX=0 that cycle; no result is delivered.
REQ-019 mdu_en_EX=1 in DONE SHALL NOT restart the MDU; a following MDU instruction SHALL start from IDLE on the next cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, counter=0, and accumulators/result=0, including mid-operation.
REQ-021 During reset stall_EX SHALL be 0 and PC_sel_EX SHALL follow its combinational inputs.

Configuration
REQ-022 With EX_MDU_EN defined, the MDU SHALL be present as specified.
REQ-023 Without EX_MDU_EN:
- mdu_en_EX SHALL be ignored.
- stall_EX SHALL be tied 0.
- ALU_result_EX SHALL be 0 for mdu_en_EX instructions.
- No MDU state SHALL exist.

Structure
REQ-024 A shared package SHALL hold the ALU opcode constants, the branch and MDU funct3 constants, and the MDU state encoding.
REQ-025 The MDU SHALL be a sub-module ex_mdu (start, op, a, b, flush -> busy, done, result); ALU and branch logic SHALL remain in ex_stage.

Verification
REQ-026 ALU_ctrl=SUB, rs1=5, rs2=7, ALU_src=0 -> ALU_result_EX=0xFFFFFFFE, stall_EX=0.
REQ-027 branch=1, funct3=LTU, rs1=1, rs2=0xFFFFFFFF, PC=0x100, imm=0x20 -> PC_sel_EX=1, PC_target_EX=0x120.
REQ-028 jalr=1, rs1=0x203, imm=0, PC=0x40 -> PC_target_EX=0x202, ALU_result_EX=0x44.
REQ-029 MUL, rs1=-3, rs2=7 -> stall_EX high 33 cycles, then ALU_result_EX=0xFFFFFFEB for 1 cycle with stall_EX=0.
REQ-030 DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> DONE after 1 cycle, result 0x80000000; DIVU by 0 -> 0xFFFFFFFF.
REQ-031 DIV, rs1=100, rs2=7 -> result 14:
- flush_EX at cycle 10 -> IDLE, stall_EX=0, no result.
- rst_n low at cycle 10 -> IDLE, stall_EX=0.
